// File: rtl/mac_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mac_share_ctrl_pkg
// Shared definitions for the MAC sharing scheduler:
//   - default widths and the MAC pipeline latency
//   - FSM state encoding (plain logic constants for legacy tools)
// ---------------------------------------------------------------------------
package mac_share_ctrl_pkg;

    localparam int DWIDTH_DEF       = 8;  // operand/result width of seq_mac
    localparam int NREQ_DEF         = 4;  // number of requesters
    localparam int LW_DEF           = 8;  // job length field width
    localparam int DRAIN_CYCLES_DEF = 3;  // a/b flop -> product reg -> accumulator

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/mac_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_share_ctrl_if
// Requester-side fabric bundle of the MAC sharing scheduler.
//   master : requester fabric (drives requests, operands, result ready)
//   slave  : mac_share_ctrl   (drives grant, operand ready, result)
// Signals:
//   req_i       per-requester job request
//   len_i       per-requester job length, flattened NREQ*LW
//   gnt_o       one-hot grant, held for the whole job
//   op_valid_i  per-requester operand beat valid
//   op_a_i/b_i  per-requester operands, flattened NREQ*DWIDTH
//   op_ready_o  granted requester's beat is taken when ready & its valid
//   res_valid_o/res_data_o/res_id_o  result and requester tag
//   res_ready_i result consumer ready
// ---------------------------------------------------------------------------
interface mac_share_ctrl_if
    import mac_share_ctrl_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NREQ   = NREQ_DEF,
    parameter int LW     = LW_DEF
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_i;
    logic [NREQ*LW-1:0]     len_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        op_valid_i;
    logic [NREQ*DWIDTH-1:0] op_a_i;
    logic [NREQ*DWIDTH-1:0] op_b_i;
    logic                   op_ready_o;
    logic                   res_valid_o;
    logic [DWIDTH-1:0]      res_data_o;
    logic [IDW-1:0]         res_id_o;
    logic                   res_ready_i;

    modport master (
        output req_i, len_i, op_valid_i, op_a_i, op_b_i, res_ready_i,
        input  gnt_o, op_ready_o, res_valid_o, res_data_o, res_id_o
    );

    modport slave (
        input  req_i, len_i, op_valid_i, op_a_i, op_b_i, res_ready_i,
        output gnt_o, op_ready_o, res_valid_o, res_data_o, res_id_o
    );

endinterface

// File: rtl/mac_share_ctrl_arb.sv
// ---------------------------------------------------------------------------
// mac_share_arb
// Picks one requester per job and holds its one-hot grant and index until
// the job's result is handed off.
// Build option: MAC_SHARE_CTRL_RR_EN
//   defined   : round-robin; search starts at a pointer that moves to one
//               past the last granted index when a job completes
//   undefined : fixed priority, lowest index wins (pointer stays at 0)
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   req         request vector
//   take        latch the current winner (scheduler is idle and accepting)
//   done        job handed off: drop the grant, advance the pointer
//   any_req     some requester is asking
//   win_idx     combinational winner index
//   gnt, id     registered one-hot grant and granted index
// ---------------------------------------------------------------------------
module mac_share_arb
    import mac_share_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic                     take,
    input  logic                     done,
    output logic                     any_req,
    output logic [$clog2(NREQ)-1:0]  win_idx,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  id
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_nxt;

    // Rotating search from the pointer; with the pointer pinned at 0 this is
    // plain lowest-index-first priority.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= NREQ) j -= NREQ;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                win_idx = IDW'(j);
            end
        end
    end

`ifdef MAC_SHARE_CTRL_RR_EN
    assign ptr_nxt = (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
`else
    assign ptr_nxt = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt   <= '0;
            id    <= '0;
            ptr_q <= '0;
        end else if (take) begin
            gnt <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            id  <= win_idx;
        end else if (done) begin
            gnt   <= '0;
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mac_share_ctrl.sv
// ---------------------------------------------------------------------------
// mac_share_ctrl
// Time-shares one seq_mac among NREQ requesters. Per job: grant, clear the
// MAC accumulator for one cycle, stream len operand pairs, wait out the MAC
// pipeline, then present the saturated dot product tagged with the id.
// Build option: MAC_SHARE_CTRL_RR_EN selects round-robin arbitration
// (see mac_share_arb); default is fixed lowest-index priority.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          requester fabric (mac_share_ctrl_if.slave)
//   mac_a_o/b_o  operands to the MAC, zero whenever no beat is accepted
//   mac_reset_o  MAC reset: system reset or the CLEAR cycle
//   mac_out_i    MAC accumulator output
// ---------------------------------------------------------------------------
module mac_share_ctrl
    import mac_share_ctrl_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int NREQ         = NREQ_DEF,
    parameter int LW           = LW_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mac_share_ctrl_if.slave   bus,
    output logic [DWIDTH-1:0] mac_a_o,
    output logic [DWIDTH-1:0] mac_b_o,
    output logic              mac_reset_o,
    input  logic [DWIDTH-1:0] mac_out_i
);
    localparam int IDW = $clog2(NREQ);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t            state_q;
    logic [LW-1:0]     rem_q;
    logic [DCW-1:0]    drain_q;
    logic [DWIDTH-1:0] res_data_q;

    logic              any_req;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    id_q;
    logic [NREQ-1:0]   gnt_q;
    logic              take;
    logic              job_done;
    logic              op_ready;
    logic              lane_valid;
    logic              accept;
    logic [LW-1:0]     win_len;

    assign take     = (state_q == ST_IDLE) && any_req;
    assign job_done = (state_q == ST_DONE) && bus.res_ready_i;

    mac_share_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_i),
        .take    (take),
        .done    (job_done),
        .any_req (any_req),
        .win_idx (win_idx),
        .gnt     (gnt_q),
        .id      (id_q)
    );

    assign win_len    = bus.len_i[win_idx*LW +: LW];
    assign lane_valid = bus.op_valid_i[id_q];

    // A zero-length job spends its single STREAM cycle with ready low.
    assign op_ready = (state_q == ST_STREAM) && (rem_q != '0);
    assign accept   = op_ready && lane_valid;

    // Bubbles feed 0*0 into the MAC, which leaves the accumulator unchanged.
    assign mac_a_o     = accept ? bus.op_a_i[id_q*DWIDTH +: DWIDTH] : '0;
    assign mac_b_o     = accept ? bus.op_b_i[id_q*DWIDTH +: DWIDTH] : '0;
    assign mac_reset_o = reset || (state_q == ST_CLEAR);

    assign bus.gnt_o       = gnt_q;
    assign bus.op_ready_o  = op_ready;
    assign bus.res_valid_o = (state_q == ST_DONE);
    assign bus.res_data_o  = res_data_q;
    assign bus.res_id_o    = id_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            drain_q    <= '0;
            res_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_CLEAR;
                        rem_q   <= win_len;
                    end
                end
                ST_CLEAR: state_q <= ST_STREAM;
                ST_STREAM: begin
                    if (accept) rem_q <= rem_q - 1'b1;
                    if ((rem_q == '0) || (accept && rem_q == LW'(1))) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    // Last beat reaches the accumulator on the final drain cycle.
                    if (drain_q == '0) begin
                        res_data_q <= mac_out_i;
                        state_q    <= ST_DONE;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_share_ctrl
// Bench for mac_share_ctrl with a behavioural signed saturating seq_mac
// (3-stage: a/b flop, product reg, saturating accumulator). Jobs come from a
// table; expected {id, data} are queued at launch and popped at the result.
// Hand-written sequence: reset during STREAM, then a fresh job.
// Honours MAC_SHARE_CTRL_RR_EN for the contention entries.
// ---------------------------------------------------------------------------
module tb_mac_share_ctrl;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int LWD = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_share_ctrl_if #(.DWIDTH(DW), .NREQ(NR), .LW(LWD)) bus ();

    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_reset;
    logic [DW-1:0] mac_out;

    mac_share_ctrl #(.DWIDTH(DW), .NREQ(NR), .LW(LWD), .DRAIN_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mac_a_o     (mac_a),
        .mac_b_o     (mac_b),
        .mac_reset_o (mac_reset),
        .mac_out_i   (mac_out)
    );

    // ---------------- seq_mac behavioural model ----------------
    logic signed [7:0]  m_a, m_b, m_acc;
    logic signed [15:0] m_p;

    function automatic logic [7:0] sat8(input int s);
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
        return 8'(s);
    endfunction

    always @(posedge clk) begin
        if (mac_reset) begin
            m_a <= '0; m_b <= '0; m_p <= '0; m_acc <= '0;
        end else begin
            m_a   <= mac_a;
            m_b   <= mac_b;
            m_p   <= m_a * m_b;
            m_acc <= sat8(int'(m_acc) + int'(m_p));
        end
    end
    assign mac_out = m_acc;

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic [3:0] req;
        int         len;
        bit         bubble;
        logic [7:0] a0;
        logic [7:0] b0;
        bit         keep;
        int         hold;
        int         exp_id;
        logic [7:0] exp_data;
        int         exp_cyc;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    function automatic vec_t mk(input logic [3:0] req, input int len, input bit bub,
                                input logic [7:0] a0, input logic [7:0] b0, input bit keep,
                                input int hold, input int id, input logic [7:0] d, input int cyc);
        vec_t v;
        v.req = req; v.len = len; v.bubble = bub; v.a0 = a0; v.b0 = b0;
        v.keep = keep; v.hold = hold; v.exp_id = id; v.exp_data = d; v.exp_cyc = cyc;
        return v;
    endfunction

    // Granted lane gets the job's operands; every other lane shouts 0x55.
    task automatic drive_lanes(input int id, input bit v, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < NR; i++) begin
            if (i == id) begin
                bus.op_valid_i[i]      = v;
                bus.op_a_i[i*DW +: DW] = a;
                bus.op_b_i[i*DW +: DW] = b;
            end else begin
                bus.op_valid_i[i]      = 1'b1;
                bus.op_a_i[i*DW +: DW] = 8'h55;
                bus.op_b_i[i*DW +: DW] = 8'h55;
            end
        end
    endtask

    // Called in an idle cycle, shortly after a falling edge.
    task automatic run_job(input vec_t v);
        int  beats = 0, first_gnt = -1, rst_first = -1, rst_cnt = 0, res_cyc = -1;
        int  bad_mac = 0, unstable = 0;
        bit  vtog = 1'b0;
        logic [7:0] ea, d0;
        logic [3:0] g0;
        logic [1:0] id0;
        sb_t e;
        sb_t s;

        bus.req_i       = v.req;
        bus.len_i       = {4{8'(v.len)}};
        bus.res_ready_i = (v.hold == 0);
        bus.op_valid_i  = '0;
        s.id = v.exp_id; s.data = v.exp_data;
        sb_q.push_back(s);
        #1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!v.keep && bus.gnt_o != '0) bus.req_i = '0;
            vtog = v.bubble ? ~vtog : 1'b1;
            ea   = v.a0 + 8'(beats);
            drive_lanes(v.exp_id, vtog, ea, v.b0);
            #1;
            if (bus.gnt_o != '0 && first_gnt < 0) first_gnt = k;
            if (mac_reset) begin
                rst_cnt++;
                if (rst_first < 0) rst_first = k;
            end
            if (bus.op_ready_o && vtog) begin
                if (mac_a !== ea || mac_b !== v.b0) bad_mac++;
                beats++;
            end else if (mac_a !== '0 || mac_b !== '0) begin
                bad_mac++;
            end
            if (bus.res_valid_o) begin
                res_cyc = k;
                break;
            end
        end
        check("result_within_budget", 32'(res_cyc > 0), 32'd1);
        e = sb_q.pop_front();
        check("res_id", 32'(bus.res_id_o), 32'(e.id));
        check("res_data", 32'(bus.res_data_o), 32'(e.data));
        check("beats_accepted", 32'(beats), 32'(v.len));
        check("mac_operands", 32'(bad_mac), 32'd0);
        check("grant_cycle", 32'(first_gnt), 32'd1);
        check("mac_reset_pulse", 32'(rst_cnt * 100 + rst_first), 32'd101);
        check("gnt_onehot", 32'(bus.gnt_o), 32'(4'b0001 << v.exp_id));
        if (v.exp_cyc != 0) check("res_valid_cycle", 32'(res_cyc), 32'(v.exp_cyc));

        if (v.hold > 0) begin
            d0 = bus.res_data_o; id0 = bus.res_id_o; g0 = bus.gnt_o;
            for (int h = 1; h <= v.hold; h++) begin
                @(negedge clk);
                bus.req_i = 4'hF;
                #1;
                if (!bus.res_valid_o || bus.res_data_o !== d0 || bus.res_id_o !== id0 ||
                    bus.gnt_o !== g0) unstable++;
            end
            check("backpressure_stable", 32'(unstable), 32'd0);
            bus.res_ready_i = 1'b1;
        end

        @(negedge clk);
        bus.op_valid_i = '0;
        if (!v.keep) bus.req_i = '0;
        #1;
        check("idle_gap_gnt", 32'(bus.gnt_o), 32'd0);
        check("idle_gap_res_valid", 32'(bus.res_valid_o), 32'd0);
    endtask

    initial begin
        bit seen;

        // Operand beat k is {a0+k, b0}; expected results follow the signed
        // 8-bit saturating accumulation of those products.
        vecs.push_back(mk(4'b0001, 4, 0, 8'd1,   8'd1,   0, 0, 0, 8'd10,  9));
        vecs.push_back(mk(4'b0001, 3, 0, 8'd1,   8'd1,   0, 0, 0, 8'd6,   8));
        vecs.push_back(mk(4'b0001, 3, 1, 8'd1,   8'd1,   0, 0, 0, 8'd6,   0));
        vecs.push_back(mk(4'b0100, 2, 0, 8'hFD,  8'd5,   0, 5, 2, 8'hE7,  0));
        vecs.push_back(mk(4'b1000, 0, 0, 8'd9,   8'd9,   0, 0, 3, 8'd0,   6));
        vecs.push_back(mk(4'b0010, 8, 0, 8'd100, 8'd100, 0, 0, 1, 8'h7F,  0));
        vecs.push_back(mk(4'b0001, 2, 0, 8'h80,  8'h7F,  0, 0, 0, 8'h80,  0));
        vecs.push_back(mk(4'b1010, 2, 0, 8'd2,   8'd3,   1, 0, 1, 8'd15,  0));
`ifdef MAC_SHARE_CTRL_RR_EN
        vecs.push_back(mk(4'b1010, 1, 0, 8'd7,   8'd7,   1, 0, 3, 8'd49,  0));
        vecs.push_back(mk(4'b1010, 1, 0, 8'd4,   8'd4,   0, 0, 1, 8'd16,  0));
`else
        vecs.push_back(mk(4'b1000, 1, 0, 8'd7,   8'd7,   0, 0, 3, 8'd49,  0));
`endif

        reset = 1'b1;
        bus.req_i = '0; bus.len_i = '0; bus.op_valid_i = '0;
        bus.op_a_i = '0; bus.op_b_i = '0; bus.res_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check("rst_op_ready", 32'(bus.op_ready_o), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        check("rst_res_data", 32'(bus.res_data_o), 32'd0);
        check("rst_res_id", 32'(bus.res_id_o), 32'd0);
        check("rst_mac_reset", 32'(mac_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_mac_reset", 32'(mac_reset), 32'd0);

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset while streaming requester 2's job.
        bus.req_i = 4'b0100;
        bus.len_i = {4{8'd4}};
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            drive_lanes(2, 1'b1, 8'd9, 8'd9);
            #1;
            seen = bus.op_ready_o;
        end
        check("midjob_streaming", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midjob_mac_reset_now", 32'(mac_reset), 32'd1);
        @(negedge clk);
        #1;
        check("midjob_gnt", 32'(bus.gnt_o), 32'd0);
        check("midjob_op_ready", 32'(bus.op_ready_o), 32'd0);
        check("midjob_res_valid", 32'(bus.res_valid_o), 32'd0);
        check("midjob_res_data", 32'(bus.res_data_o), 32'd0);
        check("midjob_res_id", 32'(bus.res_id_o), 32'd0);
        check("midjob_mac_reset", 32'(mac_reset), 32'd1);
        reset = 1'b0;
        bus.req_i = '0;
        bus.op_valid_i = '0;
        @(negedge clk);
        #1;
        check("post_reset_idle", 32'(bus.op_ready_o) + 32'(mac_reset), 32'd0);
        run_job(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
